// File: rtl/trap_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | trap_pkg : shared states, CSR addresses and cause codes, rev 1.0 |
// +------------------------------------------------------------------+
package trap_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_W_EPC    = 3'd1,
    ST_W_CAUSE  = 3'd2,
    ST_W_STATUS = 3'd3,
    ST_M_STATUS = 3'd4,
    ST_REDIRECT = 3'd5
  } trap_state_e;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam logic [30:0] CAUSE_IRQ_TIMER = 31'd7;
  localparam logic [30:0] CAUSE_IRQ_EXT   = 31'd11;

  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;
  localparam int MIE_MTIE_BIT     = 7;
  localparam int MIE_MEIE_BIT     = 11;

  // Trap entry: stash MIE in MPIE, disable interrupts, return to M-mode.
  function automatic logic [31:0] trap_mstatus(input logic [31:0] s);
    logic [31:0] r;
    r                   = s;
    r[MSTATUS_MPIE_BIT] = s[MSTATUS_MIE_BIT];
    r[MSTATUS_MIE_BIT]  = 1'b0;
    r[12:11]            = 2'b11;
    return r;
  endfunction

  function automatic logic [31:0] mret_mstatus(input logic [31:0] s);
    logic [31:0] r;
    r                   = s;
    r[MSTATUS_MIE_BIT]  = s[MSTATUS_MPIE_BIT];
    r[MSTATUS_MPIE_BIT] = 1'b1;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/trap_ctrl_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | trap_ctrl_if : pipeline/CSR bundle for trap_ctrl, rev 1.0        |
// +------------------------------------------------------------------+
interface trap_ctrl_if;
  logic        exc_valid;
  logic [30:0] exc_cause;
  logic [31:0] exc_pc;
  logic [31:0] int_pc;
  logic        irq_ext;
  logic        irq_timer;
  logic        is_mret;
  logic [31:0] mstatus_q;
  logic [31:0] mie_q;
  logic [31:0] mtvec_q;
  logic [31:0] mepc_q;
  logic        csr_we;
  logic [11:0] csr_waddr;
  logic [31:0] csr_wdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;

  modport master (
    output exc_valid, exc_cause, exc_pc, int_pc, irq_ext, irq_timer, is_mret,
    output mstatus_q, mie_q, mtvec_q, mepc_q,
    input  csr_we, csr_waddr, csr_wdata, stall, redirect, redirect_pc
  );

  modport slave (
    input  exc_valid, exc_cause, exc_pc, int_pc, irq_ext, irq_timer, is_mret,
    input  mstatus_q, mie_q, mtvec_q, mepc_q,
    output csr_we, csr_waddr, csr_wdata, stall, redirect, redirect_pc
  );
endinterface
`default_nettype wire

// File: rtl/irq_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | irq_arbiter : trap source priority and enable gating, rev 1.0    |
// +------------------------------------------------------------------+
module irq_arbiter
  import trap_pkg::*;
(
  input  logic        exc_valid,
  input  logic [30:0] exc_cause,
  input  logic        irq_ext,
  input  logic        irq_timer,
  input  logic [31:0] mie_q,
  input  logic [31:0] mstatus_q,
  output logic        take,
  output logic        is_irq,
  output logic [31:0] cause
);

  logic ext_en;
  logic timer_en;
  logic unused_csr_bits;

  assign ext_en   = irq_ext   & mie_q[MIE_MEIE_BIT] & mstatus_q[MSTATUS_MIE_BIT];
  assign timer_en = irq_timer & mie_q[MIE_MTIE_BIT] & mstatus_q[MSTATUS_MIE_BIT];

  assign unused_csr_bits = ^{mie_q[31:12], mie_q[10:8], mie_q[6:0],
                             mstatus_q[31:4], mstatus_q[2:0]};

  always_comb begin
    take   = 1'b0;
    is_irq = 1'b0;
    cause  = 32'd0;
    if (exc_valid) begin
      take  = 1'b1;
      cause = {1'b0, exc_cause};
    end else if (ext_en) begin
      take   = 1'b1;
      is_irq = 1'b1;
      cause  = {1'b1, CAUSE_IRQ_EXT};
    end else if (timer_en) begin
      take   = 1'b1;
      is_irq = 1'b1;
      cause  = {1'b1, CAUSE_IRQ_TIMER};
    end
  end

endmodule
`default_nettype wire

// File: rtl/trap_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | trap_ctrl : machine-mode trap entry / MRET CSR sequencer, rev 1.0|
// +------------------------------------------------------------------+
module trap_ctrl
  import trap_pkg::*;
#(
  parameter bit VECTORED_EN = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  trap_ctrl_if.slave    bus
);

  trap_state_e state_q, state_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] epc_q, epc_d;
  logic        is_irq_q, is_irq_d;
  logic        is_mret_q, is_mret_d;

  logic        arb_take;
  logic        arb_is_irq;
  logic [31:0] arb_cause;
  logic        accept_trap;
  logic        accept_mret;
  logic        vec_en;
  logic [31:0] tvec_base;

  logic        csr_we;
  logic [11:0] csr_waddr;
  logic [31:0] csr_wdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;

  generate
    if (VECTORED_EN) begin : g_vectored
      assign vec_en = 1'b1;
    end else begin : g_direct
      assign vec_en = 1'b0;
    end
  endgenerate

  irq_arbiter u_irq_arbiter (
    .exc_valid (bus.exc_valid),
    .exc_cause (bus.exc_cause),
    .irq_ext   (bus.irq_ext),
    .irq_timer (bus.irq_timer),
    .mie_q     (bus.mie_q),
    .mstatus_q (bus.mstatus_q),
    .take      (arb_take),
    .is_irq    (arb_is_irq),
    .cause     (arb_cause)
  );

  // Acceptance is masked by reset so stall stays low while rst is held.
  assign accept_trap = rst && (state_q == ST_IDLE) && arb_take;
  assign accept_mret = rst && (state_q == ST_IDLE) && !arb_take && bus.is_mret;
  assign tvec_base   = {bus.mtvec_q[31:2], 2'b00};

  always_comb begin
    state_d   = state_q;
    cause_d   = cause_q;
    epc_d     = epc_q;
    is_irq_d  = is_irq_q;
    is_mret_d = is_mret_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_trap) begin
          state_d   = ST_W_EPC;
          cause_d   = arb_cause;
          epc_d     = (arb_is_irq ? bus.int_pc : bus.exc_pc) & 32'hFFFF_FFFC;
          is_irq_d  = arb_is_irq;
          is_mret_d = 1'b0;
        end else if (accept_mret) begin
          state_d   = ST_M_STATUS;
          is_irq_d  = 1'b0;
          is_mret_d = 1'b1;
        end
      end
      ST_W_EPC:    state_d = ST_W_CAUSE;
      ST_W_CAUSE:  state_d = ST_W_STATUS;
      ST_W_STATUS: state_d = ST_REDIRECT;
      ST_M_STATUS: state_d = ST_REDIRECT;
      ST_REDIRECT: state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      cause_q   <= 32'd0;
      epc_q     <= 32'd0;
      is_irq_q  <= 1'b0;
      is_mret_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cause_q   <= cause_d;
      epc_q     <= epc_d;
      is_irq_q  <= is_irq_d;
      is_mret_q <= is_mret_d;
    end
  end

  always_comb begin
    csr_we      = 1'b0;
    csr_waddr   = 12'd0;
    csr_wdata   = 32'd0;
    redirect    = 1'b0;
    redirect_pc = 32'd0;
    stall       = accept_trap | accept_mret;
    if (rst) begin
      case (state_q)
        ST_W_EPC: begin
          stall     = 1'b1;
          csr_we    = 1'b1;
          csr_waddr = CSR_MEPC;
          csr_wdata = epc_q;
        end
        ST_W_CAUSE: begin
          stall     = 1'b1;
          csr_we    = 1'b1;
          csr_waddr = CSR_MCAUSE;
          csr_wdata = cause_q;
        end
        ST_W_STATUS: begin
          stall     = 1'b1;
          csr_we    = 1'b1;
          csr_waddr = CSR_MSTATUS;
          csr_wdata = trap_mstatus(bus.mstatus_q);
        end
        ST_M_STATUS: begin
          stall     = 1'b1;
          csr_we    = 1'b1;
          csr_waddr = CSR_MSTATUS;
          csr_wdata = mret_mstatus(bus.mstatus_q);
        end
        ST_REDIRECT: begin
          stall    = 1'b1;
          redirect = 1'b1;
          if (is_mret_q) begin
            redirect_pc = bus.mepc_q;
          end else if (vec_en && is_irq_q && (bus.mtvec_q[1:0] == 2'b01)) begin
            redirect_pc = tvec_base + {cause_q[29:0], 2'b00};
          end else begin
            redirect_pc = tvec_base;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.csr_we      = csr_we;
  assign bus.csr_waddr   = csr_waddr;
  assign bus.csr_wdata   = csr_wdata;
  assign bus.stall       = stall;
  assign bus.redirect    = redirect;
  assign bus.redirect_pc = redirect_pc;

endmodule
`default_nettype wire
